// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data bus controller.
package mem_bus_ctrl_pkg;

  // Controller FSM encodings (2 bits).
  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_REQ  = 2'd1,
    MB_DONE = 2'd2
  } mb_state_e;

  // Width of the REQ-cycle timeout counter.
  localparam int MB_TIMEOUT_W = 8;

endpackage : mem_bus_ctrl_pkg

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: turns the MEM stage's single-cycle request into
// a registered req/ack bus transaction, stalls the pipeline while it is
// outstanding, and reports misaligned accesses and bus timeouts.
//
// Handshake: busReq is raised one cycle after an aligned memCe is seen in IDLE
// and held, together with busWe/busAddr/busWdata, until the clock edge that
// samples busAck=1 (or the timeout abort); busAck is only honoured in REQ and
// is a single-cycle completion strobe qualifying busRdata.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memCe,
  input  logic                 memWr,
  input  logic [31:0]          memAddr,
  input  logic [31:0]          wtData,
  output logic [31:0]          rdData,
  output logic                 stall,
  output logic                 busReq,
  output logic                 busWe,
  output logic [31:0]          busAddr,
  output logic [31:0]          busWdata,
  input  logic [31:0]          busRdata,
  input  logic                 busAck,
  output logic                 alignErr,
  output logic                 busTimeout,
  output mb_state_e            dbg_state_o
);

  // Counter value seen on the last permitted REQ cycle.
  localparam logic [MB_TIMEOUT_W-1:0] TO_LAST = MB_TIMEOUT_W'(TIMEOUT - 1);

  mb_state_e                state_q, state_d;
  logic [MB_TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                     bus_req_q, bus_req_d;
  logic                     bus_we_q, bus_we_d;
  logic [31:0]              bus_addr_q, bus_addr_d;
  logic [31:0]              bus_wdata_q, bus_wdata_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic                     align_err_q, align_err_d;
  logic                     timeout_q, timeout_d;

  // Next-state and registered-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    align_err_d = align_err_q;
    timeout_d   = timeout_q;
    case (state_q)
      MB_IDLE: begin
        if (memCe) begin
          if (memAddr[1:0] == 2'b00) begin
            state_d     = MB_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = memWr;
            bus_addr_d  = {memAddr[31:2], 2'b00};
            bus_wdata_d = memWr ? wtData : 32'd0;
            cnt_d       = '0;
          end else begin
            // Misaligned: never touch the bus, report straight away.
            state_d     = MB_DONE;
            align_err_d = 1'b1;
            rd_data_d   = 32'd0;
          end
        end
      end
      MB_REQ: begin
        if (busAck) begin
          state_d   = MB_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) rd_data_d = busRdata;
        end else if (cnt_q == TO_LAST) begin
          state_d   = MB_DONE;
          bus_req_d = 1'b0;
          timeout_d = 1'b1;
          rd_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MB_DONE: begin
        // Pipeline advances this cycle; memCe still shows the old request.
        state_d     = MB_IDLE;
        align_err_d = 1'b0;
        timeout_d   = 1'b0;
      end
      default: state_d = MB_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MB_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rd_data_q   <= 32'd0;
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
      align_err_q <= align_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // Stall is the only combinational output; forced low during reset.
  assign stall = !rst && (((state_q == MB_IDLE) && memCe) || (state_q == MB_REQ));

  assign rdData      = rd_data_q;
  assign busReq      = bus_req_q;
  assign busWe       = bus_we_q;
  assign busAddr     = bus_addr_q;
  assign busWdata    = bus_wdata_q;
  assign alignErr    = align_err_q;
  assign busTimeout  = timeout_q;
  assign dbg_state_o = state_q;

endmodule : mem_bus_ctrl

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Data-memory bus controller sitting directly downstream of the MEM stage of the five-stage MIPS core. It converts MEM's single-cycle request (memCe/memWr/memAddr/wtData) into a registered req/ack transaction on the board's external data bus and returns the read word on rdData. It holds the pipeline with stall while the transaction is outstanding, and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 255: max REQ cycles without busAck before abort; 8-bit counter, legal 1..255.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high (`RstEnable = 1)
- memCe  in  1  access request from MEM (`RamEnable)
- memWr  in  1  1 = store (`RamWrite), 0 = load
- memAddr  in  32  byte address
- wtData  in  32  store data
- rdData  out  32  load data to MEM; valid in DONE
- stall  out  1  combinational hold to all upstream pipeline registers
- busReq  out  1  registered bus request
- busWe  out  1  registered bus write enable
- busAddr  out  32  registered word address, {memAddr[31:2],2'b00}
- busWdata  out  32  registered write data
- busRdata  in  32  read data, valid with busAck
- busAck  in  1  transaction-complete strobe from bus slave
- alignErr  out  1  misaligned access, high in DONE only
- busTimeout  out  1  transaction aborted, high in DONE only

## Operation
- States: IDLE, REQ, DONE.
- IDLE, memCe=0: nothing happens; stall=0.
- IDLE, memCe=1, memAddr[1:0]=00: stall=1; at edge -> REQ, latch busReq=1, busWe=memWr, busAddr, busWdata=wtData (0 for loads); clear counter.
- IDLE, memCe=1, memAddr[1:0]≠00: stall=1; at edge -> DONE with alignErr set; no bus request issued; rdData=0.
- REQ: stall=1; busReq/busWe/busAddr/busWdata held stable. At edge with busAck=1 -> DONE, busReq=0, rdData=busRdata for a load (unchanged for a store). At edge with busAck=0 and counter=TIMEOUT-1 -> DONE, busReq=0, busTimeout set, rdData=0. Otherwise counter+1.
- DONE: stall=0, so the pipeline advances at this edge; at edge -> IDLE, clear alignErr/busTimeout. The same request still present on memCe in DONE is not reissued.
- busAck outside REQ is ignored.
- Reset (any state, including mid-REQ): immediately IDLE. busReq=0, busWe=0, busAddr=0, busWdata=0, rdData=0, alignErr=0, busTimeout=0, counter=0. stall=0 while rst is high.

## Timing
- Aligned access with busAck on the first REQ cycle: 3 cycles (IDLE, REQ, DONE), stall high for 2 cycles.
- Each extra REQ cycle adds 1 cycle of stall.
- Misaligned access: 2 cycles, stall high for 1 cycle.
- Timeout: the transaction is aborted after TIMEOUT REQ cycles.
- busReq rises 1 cycle after memCe is seen in IDLE, and falls on the edge that samples busAck.
- rdData, alignErr and busTimeout are registered and change only on clk edges (or asynchronously on rst).
- stall is the only combinational output: (state==IDLE && memCe) || state==REQ.

## Structure
- Add to define.v:
  - state encodings `MbIdle/`MbReq/`MbDone (2 bits);
  - `MbTimeoutW = 8;
  - existing `RamEnable/`RamWrite/`Zero are reused.
- Single module. The timeout counter is inline; no sub-module is needed.

## Test plan
- Load from 0x0000_0010, busAck on the 1st REQ cycle with busRdata=0x1234_5678 -> busReq high 1 cycle, busAddr=0x10, busWe=0, stall high 2 cycles, rdData=0x1234_5678 in DONE.
- Store 0xCAFE_F00D to 0x0000_0020, busAck after 4 REQ cycles -> busWe=1, busWdata=0xCAFE_F00D stable all 4 cycles, stall high 5 cycles, alignErr=0.
- Load from 0x0000_0022 -> no busReq, alignErr=1 for exactly 1 cycle, stall high 1 cycle, rdData=0.
- TIMEOUT=4, busAck never asserted -> busReq high 4 cycles then drops, busTimeout=1 for 1 cycle, rdData=0, FSM back in IDLE.
- rst asserted mid-REQ (2nd cycle) -> busReq/stall drop the same cycle, all outputs 0. After release, memCe=0 keeps the FSM IDLE, and a late busAck is ignored.
- Back-to-back loads, each acked on the first REQ cycle -> 3 cycles per access, no duplicate busReq for the same instruction in DONE.
